spi_to_ctrlport: RTL and testbench
==================================

SPI_TO_CTRLPORT -- requirements
Module: spi_to_ctrlport

Interface
REQ-001 SHALL have parameter TIMEOUT_CYCLES, default 1024, meaning ctrlport_clk cycles to wait for m_ctrlport_resp_ack before aborting; range 2..65535.
REQ-002 SHALL have port ctrlport_clk  input  1  the single clock; all logic is in this domain.
REQ-003 SHALL have port ctrlport_rst  input  1  reset, asynchronous and active-high.
REQ-004 SHALL have ports m_ctrlport_req_wr, m_ctrlport_req_rd  output  1 each  one-cycle request strobes.
REQ-005 SHALL have ports m_ctrlport_req_addr  output  20 and m_ctrlport_req_data  output  32: request address and write data.
REQ-006 SHALL have ports m_ctrlport_resp_ack  input  1, m_ctrlport_resp_status  input  2 and m_ctrlport_resp_data  input  32: ControlPort response.
REQ-007 SHALL have ports sclk, cs_n, mosi  input  1 each (SPI slave, mode 0), and miso  output  1.
REQ-008 SHALL have port busy  output  1, high from request issue until response captured or timeout.

Function
REQ-009 SHALL pass sclk, cs_n and mosi through 2-flop synchronizers and detect edges on synchronized values; ctrlport_clk SHALL be >= 4x sclk.
REQ-010 SHALL use states IDLE, SHIFT, ISSUE, WAIT_RESP.
REQ-011 IDLE->SHIFT on detected cs_n falling edge: bit counter cleared, 64-bit TX shift register loaded from response register.
REQ-012 In SHIFT, SHALL sample mosi MSB-first on each detected sclk rising edge; bit counter saturates at 64; bits beyond 64 ignored.
REQ-013 Command frame: bit63 = 1 write / 0 read, bits 62:52 ignored, bits 51:32 address, bits 31:0 write data (ignored for reads).
REQ-014 On cs_n rising edge in SHIFT: count == 64 -> ISSUE; otherwise frame discarded, no request, return to IDLE.
REQ-015 ISSUE SHALL last one cycle, asserting exactly one of req_wr/req_rd with addr/data held from frame, then enter WAIT_RESP.
REQ-016 req_addr and req_data SHALL stay stable until the next ISSUE.
REQ-017 WAIT_RESP: on resp_ack, capture response register = {1'b1 valid, overrun flag, 28'b0, resp_status, resp_data}; go to IDLE, busy low next cycle.
REQ-018 miso SHALL present TX bit 63 on entry to SHIFT and shift to the next bit on each detected sclk falling edge; miso SHALL be 0 outside SHIFT.
REQ-019 Valid bit (63) SHALL clear when a frame reaches SHIFT, so each response is reported once.
REQ-020 A cs_n falling edge during ISSUE or WAIT_RESP SHALL be shifted out normally but its command discarded and overrun flag (bit 62) set; flag clears on next ISSUE.
REQ-021 resp_ack outside WAIT_RESP SHALL be ignored.

Reset
REQ-022 On ctrlport_rst: state IDLE, req_wr=req_rd=0, req_addr=0, req_data=0, miso=0, busy=0, response register and synchronizers = 0 (cs_n synchronizer = 1).
REQ-023 Reset asserted mid-frame or in WAIT_RESP SHALL abandon the transaction; no request issued after reset release until a new full frame.

Configuration
REQ-024 Macro SPI_TO_CTRLPORT_TIMEOUT_EN defined: counter runs in WAIT_RESP; after TIMEOUT_CYCLES cycles without ack, response register = valid, status 2'b01 (CMDERR), data 0; return to IDLE; a later ack is ignored.
REQ-025 Macro not defined: no counter; WAIT_RESP waits indefinitely for ack.

Verification
REQ-026 Write frame 0x8000_1234_DEAD_BEEF, ack after 3 cycles with status 0 -> one req_wr pulse, addr 0x01234, data 0xDEADBEEF; next frame miso = 0x8000_0000_DEAD_BEEF-format with status 0, valid 1.
REQ-027 Read frame 0x0000_0040_0000_0000, ack data 0xCAFEF00D status 0 -> req_rd, addr 0x00040; next frame miso 0x8000_0000_CAFE_F00D.
REQ-028 Frame of 40 bits then cs_n high -> no request, state IDLE, response unchanged.
REQ-029 New frame during WAIT_RESP (ack withheld) -> command dropped; after ack, following readout has bits 63:62 = 2'b11.
REQ-030 With SPI_TO_CTRLPORT_TIMEOUT_EN, TIMEOUT_CYCLES=16, no ack -> busy low after 16 cycles; readout 0x8000_0001_0000_0000.
REQ-031 ctrlport_rst pulsed in WAIT_RESP, then ack -> ignored, outputs at reset values, next readout all zero.

Source files
------------

// File: rtl/spi_to_ctrlport.sv
// SPI (mode 0) slave that turns 64-bit command frames into ControlPort requests and returns the last response on the next frame.
// Optional response timeout is enabled by defining SPI_TO_CTRLPORT_TIMEOUT_EN.
`timescale 1ns/1ps
module spi_to_ctrlport #(
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic        ctrlport_clk,
  input  logic        ctrlport_rst,
  output logic        m_ctrlport_req_wr,
  output logic        m_ctrlport_req_rd,
  output logic [19:0] m_ctrlport_req_addr,
  output logic [31:0] m_ctrlport_req_data,
  input  logic        m_ctrlport_resp_ack,
  input  logic [1:0]  m_ctrlport_resp_status,
  input  logic [31:0] m_ctrlport_resp_data,
  input  logic        sclk,
  input  logic        cs_n,
  input  logic        mosi,
  output logic        miso,
  output logic        busy
);

  typedef enum logic [1:0] {IDLE, SHIFT, ISSUE, WAIT_RESP} state_t;

  state_t      state;
  logic [2:0]  sclk_sync;
  logic [2:0]  cs_n_sync;
  logic [1:0]  mosi_sync;
  logic        sclk_rise, sclk_fall, cs_fall, cs_rise;
  logic        frame_active;
  logic [6:0]  bit_cnt;
  logic [63:0] rx_sr;
  logic [63:0] tx_sr;
  logic [63:0] resp_reg;
  logic        ovr_flag;
`ifdef SPI_TO_CTRLPORT_TIMEOUT_EN
  logic [15:0] tmo_cnt;
`endif

  // Two synchronizer stages plus one history stage for edge detection.
  always_ff @(posedge ctrlport_clk or posedge ctrlport_rst) begin
    if (ctrlport_rst) begin
      sclk_sync <= 3'b000;
      cs_n_sync <= 3'b111;
      mosi_sync <= 2'b00;
    end else begin
      sclk_sync <= {sclk_sync[1:0], sclk};
      cs_n_sync <= {cs_n_sync[1:0], cs_n};
      mosi_sync <= {mosi_sync[0], mosi};
    end
  end

  assign sclk_rise = sclk_sync[1] & ~sclk_sync[2];
  assign sclk_fall = ~sclk_sync[1] & sclk_sync[2];
  assign cs_fall   = ~cs_n_sync[1] & cs_n_sync[2];
  assign cs_rise   = cs_n_sync[1] & ~cs_n_sync[2];

  // Frame shifter runs for every frame, including ones that arrive while a request is outstanding.
  always_ff @(posedge ctrlport_clk or posedge ctrlport_rst) begin
    if (ctrlport_rst) begin
      frame_active <= 1'b0;
      bit_cnt      <= 7'd0;
      rx_sr        <= 64'd0;
      tx_sr        <= 64'd0;
    end else if (cs_fall) begin
      frame_active <= 1'b1;
      bit_cnt      <= 7'd0;
      tx_sr        <= resp_reg;
    end else if (cs_rise) begin
      frame_active <= 1'b0;
    end else if (frame_active) begin
      if (sclk_rise && bit_cnt != 7'd64) begin
        rx_sr   <= {rx_sr[62:0], mosi_sync[1]};
        bit_cnt <= bit_cnt + 7'd1;
      end
      if (sclk_fall)
        tx_sr <= {tx_sr[62:0], 1'b0};
    end
  end

  assign miso = frame_active & tx_sr[63];

  always_ff @(posedge ctrlport_clk or posedge ctrlport_rst) begin
    if (ctrlport_rst) begin
      state               <= IDLE;
      m_ctrlport_req_wr   <= 1'b0;
      m_ctrlport_req_rd   <= 1'b0;
      m_ctrlport_req_addr <= 20'd0;
      m_ctrlport_req_data <= 32'd0;
      busy                <= 1'b0;
      resp_reg            <= 64'd0;
      ovr_flag            <= 1'b0;
`ifdef SPI_TO_CTRLPORT_TIMEOUT_EN
      tmo_cnt             <= 16'd0;
`endif
    end else begin
      m_ctrlport_req_wr <= 1'b0;
      m_ctrlport_req_rd <= 1'b0;
      // Each response is reported once; a capture below overrides this clear.
      if (cs_fall) begin
        resp_reg[63] <= 1'b0;
        if (state == ISSUE || state == WAIT_RESP)
          ovr_flag <= 1'b1;
      end
      case (state)
        IDLE:
          if (cs_fall)
            state <= SHIFT;
        SHIFT:
          if (cs_rise) begin
            if (bit_cnt == 7'd64) begin
              state               <= ISSUE;
              m_ctrlport_req_wr   <= rx_sr[63];
              m_ctrlport_req_rd   <= ~rx_sr[63];
              m_ctrlport_req_addr <= rx_sr[51:32];
              m_ctrlport_req_data <= rx_sr[31:0];
              busy                <= 1'b1;
              ovr_flag            <= 1'b0;
`ifdef SPI_TO_CTRLPORT_TIMEOUT_EN
              tmo_cnt             <= 16'(TIMEOUT_CYCLES - 1);
`endif
            end else begin
              state <= IDLE;
            end
          end
        ISSUE:
          state <= WAIT_RESP;
        WAIT_RESP:
          if (m_ctrlport_resp_ack) begin
            resp_reg <= {1'b1, ovr_flag, 28'd0, m_ctrlport_resp_status, m_ctrlport_resp_data};
            busy     <= 1'b0;
            state    <= IDLE;
          end
`ifdef SPI_TO_CTRLPORT_TIMEOUT_EN
          else if (tmo_cnt == 16'd0) begin
            resp_reg <= {1'b1, ovr_flag, 28'd0, 2'b01, 32'd0};
            busy     <= 1'b0;
            state    <= IDLE;
          end else begin
            tmo_cnt <= tmo_cnt - 16'd1;
          end
`endif
        default:
          state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_spi_to_ctrlport.sv
// Directed bench for spi_to_ctrlport: vector table of full transactions plus hand-written overrun/reset/short-frame sequences.
`timescale 1ns/1ps
module tb_spi_to_ctrlport;

`ifdef SPI_TO_CTRLPORT_TIMEOUT_EN
  localparam int TMO = 16;
`else
  localparam int TMO = 1024;
`endif
  localparam int HALF = 50;

  logic        ctrlport_clk = 1'b0;
  logic        ctrlport_rst = 1'b1;
  logic        m_ctrlport_req_wr, m_ctrlport_req_rd;
  logic [19:0] m_ctrlport_req_addr;
  logic [31:0] m_ctrlport_req_data;
  logic        m_ctrlport_resp_ack = 1'b0;
  logic [1:0]  m_ctrlport_resp_status = 2'b00;
  logic [31:0] m_ctrlport_resp_data = 32'd0;
  logic        sclk = 1'b0, cs_n = 1'b1, mosi = 1'b0;
  logic        miso, busy;

  spi_to_ctrlport #(.TIMEOUT_CYCLES(TMO)) dut (
    .ctrlport_clk(ctrlport_clk), .ctrlport_rst(ctrlport_rst),
    .m_ctrlport_req_wr(m_ctrlport_req_wr), .m_ctrlport_req_rd(m_ctrlport_req_rd),
    .m_ctrlport_req_addr(m_ctrlport_req_addr), .m_ctrlport_req_data(m_ctrlport_req_data),
    .m_ctrlport_resp_ack(m_ctrlport_resp_ack), .m_ctrlport_resp_status(m_ctrlport_resp_status),
    .m_ctrlport_resp_data(m_ctrlport_resp_data),
    .sclk(sclk), .cs_n(cs_n), .mosi(mosi), .miso(miso), .busy(busy)
  );

  always #5 ctrlport_clk = ~ctrlport_clk;

  int tests = 0;
  int fails = 0;
  int wr_cnt = 0;
  int rd_cnt = 0;
  logic [19:0] mon_addr = 20'd0;
  logic [31:0] mon_data = 32'd0;

  always @(negedge ctrlport_clk) begin
    if (m_ctrlport_req_wr) begin
      wr_cnt++;
      mon_addr = m_ctrlport_req_addr;
      mon_data = m_ctrlport_req_data;
    end
    if (m_ctrlport_req_rd) begin
      rd_cnt++;
      mon_addr = m_ctrlport_req_addr;
      mon_data = m_ctrlport_req_data;
    end
  end

  typedef struct {
    logic [63:0] cmd;
    logic [1:0]  st;
    logic [31:0] rdata;
    logic        exp_wr;
    logic [19:0] exp_addr;
    logic [31:0] exp_data;
    logic [63:0] exp_miso;
  } vec_t;

  vec_t vecs[4];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // rst_bit >= 0 pulses reset while sclk is low before that bit.
  task automatic spi_frame(input logic [63:0] cmd, input int nbits, input int rst_bit,
                           output logic [63:0] rx);
    rx = 64'd0;
    cs_n = 1'b0;
    #(HALF);
    for (int i = 0; i < nbits; i++) begin
      mosi = cmd[63-i];
      if (i == rst_bit) begin
        ctrlport_rst = 1'b1;
        #20;
        ctrlport_rst = 1'b0;
      end
      #(HALF);
      rx[63-i] = miso;
      sclk = 1'b1;
      #(HALF);
      sclk = 1'b0;
    end
    #(HALF);
    cs_n = 1'b1;
    mosi = 1'b0;
    #(2*HALF);
  endtask

  task automatic send_ack(input logic [1:0] st, input logic [31:0] d);
    @(negedge ctrlport_clk);
    m_ctrlport_resp_ack    = 1'b1;
    m_ctrlport_resp_status = st;
    m_ctrlport_resp_data   = d;
    @(negedge ctrlport_clk);
    m_ctrlport_resp_ack    = 1'b0;
    m_ctrlport_resp_status = 2'b00;
    m_ctrlport_resp_data   = 32'd0;
  endtask

  initial begin
    logic [63:0] rx;
    int wr0, rd0;

    vecs[0] = '{64'h8000_1234_DEAD_BEEF, 2'd0, 32'hDEAD_BEEF, 1'b1, 20'h01234, 32'hDEAD_BEEF, 64'h0};
    vecs[1] = '{64'h0000_0040_0000_0000, 2'd0, 32'hCAFE_F00D, 1'b0, 20'h00040, 32'h0, 64'h8000_0000_DEAD_BEEF};
    vecs[2] = '{64'h8FFF_FFFF_0000_0001, 2'd2, 32'h0BAD_C0DE, 1'b1, 20'hFFFFF, 32'h0000_0001, 64'h8000_0000_CAFE_F00D};
    vecs[3] = '{64'h7FF5_4321_FFFF_FFFF, 2'd3, 32'h1234_5678, 1'b0, 20'h54321, 32'h0, 64'h8000_0002_0BAD_C0DE};

    repeat (3) @(negedge ctrlport_clk);
    check("reset_req_wr", 64'(m_ctrlport_req_wr), 64'd0);
    check("reset_req_rd", 64'(m_ctrlport_req_rd), 64'd0);
    check("reset_addr", 64'(m_ctrlport_req_addr), 64'd0);
    check("reset_data", 64'(m_ctrlport_req_data), 64'd0);
    check("reset_busy", 64'(busy), 64'd0);
    check("reset_miso", 64'(miso), 64'd0);
    ctrlport_rst = 1'b0;
    repeat (3) @(negedge ctrlport_clk);

    for (int v = 0; v < 4; v++) begin
      wr0 = wr_cnt;
      rd0 = rd_cnt;
      spi_frame(vecs[v].cmd, 64, -1, rx);
      check($sformatf("v%0d_miso", v), rx, vecs[v].exp_miso);
      check($sformatf("v%0d_wr_pulses", v), 64'(wr_cnt - wr0), 64'(vecs[v].exp_wr));
      check($sformatf("v%0d_rd_pulses", v), 64'(rd_cnt - rd0), 64'(!vecs[v].exp_wr));
      check($sformatf("v%0d_addr", v), 64'(mon_addr), 64'(vecs[v].exp_addr));
      if (vecs[v].exp_wr)
        check($sformatf("v%0d_data", v), 64'(mon_data), 64'(vecs[v].exp_data));
      repeat (3) @(negedge ctrlport_clk);
      check($sformatf("v%0d_busy_wait", v), 64'(busy), 64'd1);
      send_ack(vecs[v].st, vecs[v].rdata);
      check($sformatf("v%0d_busy_done", v), 64'(busy), 64'd0);
    end

    // Short frame: partial readout, no request, valid bit cleared afterwards.
    wr0 = wr_cnt;
    rd0 = rd_cnt;
    spi_frame(64'h8000_1234_DEAD_BEEF, 40, -1, rx);
    check("short_miso", 64'(rx[63:24]), 64'h80_0000_0312);
    check("short_no_req", 64'((wr_cnt - wr0) + (rd_cnt - rd0)), 64'd0);
    check("short_busy", 64'(busy), 64'd0);

    // Overrun: second frame while the first request is outstanding.
    wr0 = wr_cnt;
    rd0 = rd_cnt;
    spi_frame(64'h0000_000A_0000_0000, 64, -1, rx);
    check("ovr_f1_miso", rx, 64'h0000_0003_1234_5678);
    check("ovr_f1_rd", 64'(rd_cnt - rd0), 64'd1);
    check("ovr_f1_busy", 64'(busy), 64'd1);
    spi_frame(64'h8000_0BBB_0000_0000, 64, -1, rx);
    check("ovr_f2_miso", rx, 64'h0000_0003_1234_5678);
    check("ovr_f2_no_req", 64'((wr_cnt - wr0) + (rd_cnt - rd0)), 64'd1);
    check("ovr_addr_stable", 64'(m_ctrlport_req_addr), 64'h0000A);
    send_ack(2'd0, 32'h0000_AAAA);
    check("ovr_busy_done", 64'(busy), 64'd0);
    spi_frame(64'h0, 64, -1, rx);
    check("ovr_readout", rx, 64'hC000_0000_0000_AAAA);
    repeat (2) @(negedge ctrlport_clk);
    send_ack(2'd0, 32'h0000_0055);

    // Reset while waiting for a response.
    spi_frame(64'h0000_0123_0000_0000, 64, -1, rx);
    check("rst_f4_miso", rx, 64'h8000_0000_0000_0055);
    check("rst_f4_busy", 64'(busy), 64'd1);
    @(negedge ctrlport_clk);
    ctrlport_rst = 1'b1;
    @(negedge ctrlport_clk);
    ctrlport_rst = 1'b0;
    check("rst_addr", 64'(m_ctrlport_req_addr), 64'd0);
    check("rst_busy", 64'(busy), 64'd0);
    wr0 = wr_cnt;
    rd0 = rd_cnt;
    send_ack(2'd0, 32'h0000_0066);
    repeat (3) @(negedge ctrlport_clk);
    check("rst_ack_ignored_busy", 64'(busy), 64'd0);
    check("rst_ack_no_req", 64'((wr_cnt - wr0) + (rd_cnt - rd0)), 64'd0);
    spi_frame(64'h8000_0002_0000_0005, 64, -1, rx);
    check("rst_readout_zero", rx, 64'd0);
    check("f5_wr", 64'(wr_cnt - wr0), 64'd1);
    check("f5_addr", 64'(mon_addr), 64'h00002);
    check("f5_data", 64'(mon_data), 64'h5);
    send_ack(2'd0, 32'h0000_0077);

    // Reset mid-frame: remainder of the frame must not issue anything.
    wr0 = wr_cnt;
    rd0 = rd_cnt;
    spi_frame(64'h8000_0999_1111_2222, 64, 30, rx);
    repeat (3) @(negedge ctrlport_clk);
    check("midrst_no_req", 64'((wr_cnt - wr0) + (rd_cnt - rd0)), 64'd0);
    check("midrst_busy", 64'(busy), 64'd0);
    spi_frame(64'h0, 64, -1, rx);
    check("midrst_readout_zero", rx, 64'd0);
    send_ack(2'd0, 32'h0000_0099);

`ifdef SPI_TO_CTRLPORT_TIMEOUT_EN
    begin
      int n;
      spi_frame(64'h0, 64, -1, rx);
      check("tmo_f7_miso", rx, 64'h8000_0000_0000_0099);
      n = 0;
      while (busy && n < 60) begin
        @(negedge ctrlport_clk);
        n++;
      end
      check("tmo_busy_cleared", 64'(busy), 64'd0);
      send_ack(2'd0, 32'h1234_0000);
      spi_frame(64'h0, 64, -1, rx);
      check("tmo_readout", rx, 64'h8000_0001_0000_0000);
      repeat (30) @(negedge ctrlport_clk);
    end
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
